cla_add_arbiter: RTL

Shares a single `cla_8` carry-lookahead adder between two requesters and sequences it byte-serially to perform `8*NBYTE`-bit additions. Each accepted operation runs one byte per cycle, least-significant byte first, with a registered carry chained between bytes. It sits between the squaring/threshold datapath clients and the adder, replacing per-client wide adders with one time-multiplexed `cla_8`.

---
 rtl/cla_add_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cla_add_arbiter.sv
// Two-channel arbiter sharing one cla_8, run byte-serially to form 8*NBYTE-bit sums.
// Define CLA_ARB_RR_EN for round-robin arbitration; otherwise ch0 has fixed priority.

module cla_8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       c_in,
   output logic [7:0] s,
   output logic       g_out,
   output logic       p_out
);
   logic [7:0] g, p;
   logic [8:0] gc, pc, c;
   logic       pp;

   // Each carry is a flat sum of products: g[j] & p[j+1..i], plus c_in & p[0..i].
   always_comb begin
      g  = a & b;
      p  = a ^ b;
      gc = '0;
      pc = '0;
      pp = 1'b0;
      for (int i = 0; i < 8; i++) begin
         gc[i+1] = g[i];
         pp      = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            gc[i+1] = gc[i+1] | (g[j] & pp);
            pp      = pp & p[j];
         end
         pc[i+1] = pp;
      end
      c = gc | ({9{c_in}} & pc);
      c[0] = c_in;
   end

   assign s     = p ^ c[7:0];
   assign g_out = gc[8];
   assign p_out = &p;
endmodule

module cla_add_arbiter #(
   parameter  int NBYTE = 2,
   localparam int W     = 8 * NBYTE
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         ack0,
   output logic         ack1,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_co,
   output logic         out_id
);
   localparam int CW = (NBYTE > 1) ? $clog2(NBYTE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state;
   logic [NBYTE-1:0][7:0] a_q, b_q, sum_q;
   logic                  carry;
   logic [CW-1:0]         cnt;
   logic [7:0]            s;
   logic                  g_out, p_out, c_nxt;
   logic                  win1, accept;

`ifdef CLA_ARB_RR_EN
   logic last;
   // On a tie the channel not granted last time wins.
   assign win1 = req1 & (~req0 | ~last);
`else
   assign win1 = req1 & ~req0;
`endif

   // The handshake edge in DONE doubles as the IDLE sampling edge, so a waiting
   // request is picked up there and throughput is one op per NBYTE+1 cycles.
   assign accept = (req0 | req1) & ((state == IDLE) | ((state == DONE) & out_ready));

   cla_8 u_cla (
      .a     (a_q[cnt]),
      .b     (b_q[cnt]),
      .c_in  (carry),
      .s     (s),
      .g_out (g_out),
      .p_out (p_out)
   );

   assign c_nxt   = g_out | (p_out & carry);
   assign out_sum = sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         out_valid <= 1'b0;
         out_co    <= 1'b0;
         out_id    <= 1'b0;
`ifdef CLA_ARB_RR_EN
         last      <= 1'b1;
`endif
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            RUN: begin
               sum_q[cnt] <= s;
               carry      <= c_nxt;
               if (cnt == CW'(NBYTE - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_co    <= c_nxt;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
         if (accept) begin
            state  <= RUN;
            a_q    <= win1 ? a1 : a0;
            b_q    <= win1 ? b1 : b0;
            carry  <= 1'b0;
            cnt    <= '0;
            ack0   <= ~win1;
            ack1   <= win1;
            out_id <= win1;
`ifdef CLA_ARB_RR_EN
            last   <= win1;
`endif
         end
      end
   end
endmodule
